// File: rtl/display_scan_multiplexer.sv
// Time-multiplexes packed hex nibbles onto one shared seven-segment decoder with active-low anodes.
// Optional: define DISPLAY_LEADING_ZERO_BLANK_EN to keep leading-zero digits dark.
module display_scan_multiplexer #(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned BLANK_CYCLES = 2400,
  parameter int unsigned DIGIT_CYCLES = 24000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    display_on,
  output logic [3:0]              value,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int unsigned MaxCycles = (BLANK_CYCLES > DIGIT_CYCLES) ? BLANK_CYCLES : DIGIT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam int unsigned IdxW      = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {StBlank, StShow} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [3:0]              value_q, value_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   shown;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StBlank;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_q       <= '0;
      value_q      <= 4'h0;
      digit_en_q   <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      value_q      <= value_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Scan sequencer: BLANK then SHOW for each digit, wrapping idx at the end of the frame.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;

    // Frame-coherent capture: only at the very first cycle of a frame.
    if (state_q == StBlank && idx_q == '0 && cnt_q == '0) begin
      snap_d = digits;
    end

    unique case (state_q)
      StBlank: begin
        if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
          state_d = StShow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShow: begin
        if (cnt_q == CntW'(DIGIT_CYCLES - 1)) begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  // A digit is shown if it or any more-significant digit is non-zero; digit 0 always shows.
  always_comb begin
    logic any_nz;
    any_nz = 1'b0;
    shown  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_nz   = any_nz | (|snap_d[4*i +: 4]);
      shown[i] = any_nz | (i == 0);
    end
  end
`else
  assign shown = '1;
`endif

  // Outputs are registered from next state so they line up with the state they describe.
  always_comb begin
    value_d      = 4'h0;
    digit_en_d   = '1;
    frame_done_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IdxW'(i)) begin
        value_d = snap_d[4*i +: 4];
        if (state_d == StShow) begin
          digit_en_d[i] = ~(display_on & shown[i]);
        end
      end
    end
    frame_done_d = (state_d == StShow) && (idx_d == IdxW'(NUM_DIGITS - 1)) &&
                   (cnt_d == CntW'(DIGIT_CYCLES - 1));
  end

  assign value      = value_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_multiplexer.sv
// Directed and model-scored bench for display_scan_multiplexer (NUM_DIGITS=2, BLANK=2, DIGIT=5).
module tb_display_scan_multiplexer;

  localparam int N  = 2;
  localparam int BC = 2;
  localparam int DC = 5;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] digits;
  logic       display_on;
  logic [3:0] value;
  logic [1:0] digit_en;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int total = 0;

  // Reference model of the scan state, advanced once per rising edge.
  bit         m_blank = 1'b1;
  int         m_idx   = 0;
  int         m_cnt   = 0;
  logic [7:0] m_snap  = 8'h00;
  logic       m_don   = 1'b0;

  always #5 clk = ~clk;

  display_scan_multiplexer #(
    .NUM_DIGITS  (N),
    .BLANK_CYCLES(BC),
    .DIGIT_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits    (digits),
    .display_on(display_on),
    .value     (value),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  task automatic chk_model();
    logic [1:0] e_en;
    logic [3:0] e_val;
    logic       e_fd;
    bit         vis;
    e_val = (m_idx == 0) ? m_snap[3:0] : m_snap[7:4];
    e_en  = 2'b11;
    if (!m_blank) begin
      vis = (m_idx == 0) || !Lzb || (m_snap[7:4] != 4'h0);
      if (m_don && vis) begin
        if (m_idx == 0) e_en[0] = 1'b0;
        else            e_en[1] = 1'b0;
      end
    end
    e_fd = !m_blank && (m_idx == N - 1) && (m_cnt == DC - 1);
    chk("model_en", {6'b0, digit_en}, {6'b0, e_en});
    chk("model_value", {4'b0, value}, {4'b0, e_val});
    chk("model_frame_done", {7'b0, frame_done}, {7'b0, e_fd});
  endtask

  // Hand-written timeline of the first frame after reset with display_on=1.
  task automatic chk_first(input int c, input logic [3:0] lo, input logic [3:0] hi);
    logic [1:0] e_en;
    logic [3:0] e_val;
    if (c < 2)      e_en = 2'b11;
    else if (c < 7) e_en = 2'b10;
    else if (c < 9) e_en = 2'b11;
    else            e_en = 2'b01;
    if (c == 0)     e_val = 4'h0;
    else if (c < 7) e_val = lo;
    else            e_val = hi;
    chk("first_en", {6'b0, digit_en}, {6'b0, e_en});
    chk("first_value", {4'b0, value}, {4'b0, e_val});
    chk("first_frame_done", {7'b0, frame_done}, {7'b0, (c == 13)});
  endtask

  task automatic tick();
    if (reset) begin
      m_blank = 1'b1;
      m_idx   = 0;
      m_cnt   = 0;
      m_snap  = 8'h00;
    end else begin
      if (m_blank && m_idx == 0 && m_cnt == 0) m_snap = digits;
      if (m_blank) begin
        if (m_cnt == BC - 1) begin
          m_blank = 1'b0;
          m_cnt   = 0;
        end else m_cnt++;
      end else if (m_cnt == DC - 1) begin
        m_blank = 1'b1;
        m_cnt   = 0;
        m_idx   = (m_idx + 1) % N;
      end else m_cnt++;
    end
    m_don = display_on;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    total++;
  endtask

  initial begin
    reset      = 1'b1;
    digits     = 8'hA5;
    display_on = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    chk("reset_en", {6'b0, digit_en}, 8'h03);
    chk("reset_value", {4'b0, value}, 8'h00);
    chk("reset_frame_done", {7'b0, frame_done}, 8'h00);
    reset = 1'b0;
    cyc   = 0;

    // Frame 1: A5 captured; digits change mid-frame at cycle 8.
    while (cyc <= 13) begin
      chk_model();
      chk_first(cyc, 4'h5, 4'hA);
      if (cyc == 8) digits = 8'h3C;
      tick();
    end

    // Frames 2-3: new snapshot, display dark over cycles 20-30, reset during digit-1 SHOW.
    while (cyc <= 37) begin
      chk_model();
      case (cyc)
        14: begin
          chk("f2_c14_value", {4'b0, value}, 8'h05);
          chk("f2_c14_en", {6'b0, digit_en}, 8'h03);
        end
        15: chk("f2_c15_value", {4'b0, value}, 8'h0C);
        17: begin
          chk("f2_d0_en", {6'b0, digit_en}, 8'h02);
          chk("f2_d0_value", {4'b0, value}, 8'h0C);
        end
        20, 24, 30: chk("dark_en", {6'b0, digit_en}, 8'h03);
        23: chk("f2_d1_value", {4'b0, value}, 8'h03);
        26: chk("dark_fd_low", {7'b0, frame_done}, 8'h00);
        27: chk("dark_fd_pulse", {7'b0, frame_done}, 8'h01);
        31: begin
          chk("resume_en", {6'b0, digit_en}, 8'h02);
          chk("resume_value", {4'b0, value}, 8'h0C);
        end
        37: chk("f3_d1_en", {6'b0, digit_en}, 8'h01);
        default: ;
      endcase
      if (cyc == 19) display_on = 1'b0;
      if (cyc == 30) display_on = 1'b1;
      if (cyc == 37) reset = 1'b1;
      tick();
    end

    chk("midreset_en", {6'b0, digit_en}, 8'h03);
    chk("midreset_value", {4'b0, value}, 8'h00);
    chk("midreset_frame_done", {7'b0, frame_done}, 8'h00);
    reset = 1'b0;
    cyc   = 0;

    // Timeline repeats with 3C; then 07 exercises leading-zero handling.
    while (cyc <= 27) begin
      chk_model();
      if (cyc <= 13) chk_first(cyc, 4'hC, 4'h3);
      if (cyc == 17) begin
        chk("lz_d0_en", {6'b0, digit_en}, 8'h02);
        chk("lz_d0_value", {4'b0, value}, 8'h07);
      end
      if (cyc == 24) begin
        chk("lz_d1_en", {6'b0, digit_en}, Lzb ? 8'h03 : 8'h01);
        chk("lz_d1_value", {4'b0, value}, 8'h00);
      end
      if (cyc == 13) digits = 8'h07;
      tick();
    end

    // Randomised soak scored against the model every cycle.
    repeat (1000) begin
      chk_model();
      if ($urandom_range(0, 9) == 0) digits = 8'($urandom);
      if ($urandom_range(0, 15) == 0) display_on = ~display_on;
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    chk_model();

    $display("cycles simulated: %0d, errors: %0d", total, n_bad);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
